// File: rtl/intersection_ctrl.sv
// Two-approach traffic controller with all-red clearance and rest-on-green.
// Optional pedestrian walk phase is compiled in with `define PED_WALK_EN.
module intersection_ctrl #(
  parameter int GREEN_CYC  = 30,
  parameter int YELLOW_CYC = 10,
  parameter int ALLRED_CYC = 4,
  parameter int WALK_CYC   = 20,
  parameter int TW         = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       ns_req,
  input  logic       ew_req,
  input  logic       ped_req,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic       ped_wait,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    AR_NS = 3'd3,
    EW_G  = 3'd4,
    EW_Y  = 3'd5,
    AR_EW = 3'd6,
    WALK  = 3'd7
  } state_t;

  localparam logic [TW-1:0] G_LAST = TW'(GREEN_CYC - 1);
  localparam logic [TW-1:0] Y_LAST = TW'(YELLOW_CYC - 1);
  localparam logic [TW-1:0] A_LAST = TW'(ALLRED_CYC - 1);
  localparam logic [TW-1:0] W_LAST = TW'(WALK_CYC - 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic          next_dir_ew;
  logic          ped_pending;

`ifdef PED_WALK_EN
  logic enter_walk;

  assign enter_walk = (state == AR_NS || state == AR_EW) && (timer == A_LAST) && ped_pending;

  // Entering or occupying WALK serves the request; a press on that edge is absorbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_pending <= 1'b0;
    end else if (!enable) begin
      ped_pending <= 1'b0;
    end else if (enter_walk || state == WALK) begin
      ped_pending <= 1'b0;
    end else if (ped_req) begin
      ped_pending <= 1'b1;
    end
  end

  assign walk = (state == WALK);
`else
  logic ped_req_unused;

  assign ped_req_unused = ped_req;
  assign ped_pending    = 1'b0;
  assign walk           = 1'b0;
`endif

  assign ped_wait  = ped_pending;
  assign state_out = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= OFF;
      timer       <= '0;
      next_dir_ew <= 1'b0;
    end else if (!enable) begin
      state <= OFF;
      timer <= '0;
    end else begin
      case (state)
        OFF: begin
          state       <= AR_EW;
          next_dir_ew <= 1'b0;
          timer       <= '0;
        end
        // Greens hold the timer at its last value while resting.
        NS_G: begin
          if (timer == G_LAST) begin
            if (ew_req || ped_pending) begin
              state <= NS_Y;
              timer <= '0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        EW_G: begin
          if (timer == G_LAST) begin
            if (ns_req || ped_pending) begin
              state <= EW_Y;
              timer <= '0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        NS_Y: begin
          if (timer == Y_LAST) begin
            state       <= AR_NS;
            next_dir_ew <= 1'b1;
            timer       <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        EW_Y: begin
          if (timer == Y_LAST) begin
            state       <= AR_EW;
            next_dir_ew <= 1'b0;
            timer       <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        AR_NS, AR_EW: begin
          if (timer == A_LAST) begin
            timer <= '0;
            if (ped_pending) state <= WALK;
            else             state <= next_dir_ew ? EW_G : NS_G;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`ifdef PED_WALK_EN
        WALK: begin
          if (timer == W_LAST) begin
            timer <= '0;
            state <= next_dir_ew ? EW_G : NS_G;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif
        default: begin
          state <= OFF;
          timer <= '0;
        end
      endcase
    end
  end

`ifndef PED_WALK_EN
  logic [TW-1:0] w_last_unused;
  assign w_last_unused = W_LAST;
`endif

  always_comb begin
    ns_red    = 1'b0;
    ns_yellow = 1'b0;
    ns_green  = 1'b0;
    ew_red    = 1'b0;
    ew_yellow = 1'b0;
    ew_green  = 1'b0;
    case (state)
      NS_G: begin ns_green  = 1'b1; ew_red = 1'b1; end
      NS_Y: begin ns_yellow = 1'b1; ew_red = 1'b1; end
      EW_G: begin ew_green  = 1'b1; ns_red = 1'b1; end
      EW_Y: begin ew_yellow = 1'b1; ns_red = 1'b1; end
      AR_NS, AR_EW, WALK: begin ns_red = 1'b1; ew_red = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed + randomized bench for intersection_ctrl against a phase-table model.
// Pedestrian steps are exercised only when PED_WALK_EN is defined.
module tb_intersection_ctrl;

  localparam int G = 5;
  localparam int Y = 3;
  localparam int A = 2;
  localparam int W = 4;
`ifdef PED_WALK_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, enable, ns_req, ew_req, ped_req;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
  logic       walk, ped_wait;
  logic [2:0] state_out;

  intersection_ctrl #(
    .GREEN_CYC(G), .YELLOW_CYC(Y), .ALLRED_CYC(A), .WALK_CYC(W), .TW(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .ns_req(ns_req), .ew_req(ew_req), .ped_req(ped_req),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .walk(walk), .ped_wait(ped_wait), .state_out(state_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Model: phase number, cycles in phase, pending press, next green is EW.
  int m_st, m_t;
  bit m_ped, m_ew;

  function automatic int dur(int s);
    case (s)
      1, 4:    return G;
      2, 5:    return Y;
      3, 6:    return A;
      7:       return W;
      default: return 1;
    endcase
  endfunction

  // {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}
  function automatic logic [6:0] lamps(int s);
    case (s)
      1:       return 7'b001_100_0;
      2:       return 7'b010_100_0;
      4:       return 7'b100_001_0;
      5:       return 7'b100_010_0;
      3, 6:    return 7'b100_100_0;
      7:       return 7'b100_100_1;
      default: return 7'b000_000_0;
    endcase
  endfunction

  task automatic model_step();
    int nxt;
    bit done;
    if (!enable) begin
      m_st = 0; m_t = 0; m_ped = 0;
      return;
    end
    nxt  = m_st;
    done = (m_t == dur(m_st) - 1);
    case (m_st)
      0: begin nxt = 6; m_ew = 0; end
      1: if (done && (ew_req || m_ped)) nxt = 2;
      4: if (done && (ns_req || m_ped)) nxt = 5;
      2: if (done) begin nxt = 3; m_ew = 1; end
      5: if (done) begin nxt = 6; m_ew = 0; end
      3, 6, 7: if (done) nxt = (m_st != 7 && m_ped) ? 7 : (m_ew ? 4 : 1);
      default: nxt = 0;
    endcase
    if (PED) begin
      if (nxt == 7 || m_st == 7) m_ped = 0;
      else if (ped_req)          m_ped = 1;
    end
    if (nxt != m_st)             m_t = 0;
    else if (m_t < dur(m_st) - 1) m_t = m_t + 1;
    m_st = nxt;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("state", int'(state_out), m_st);
    chk("lamps", int'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}),
        int'(lamps(m_st)));
    chk("ped_wait", int'(ped_wait), int'(m_ped));
    chk("green_excl", int'(ns_green & ew_green), 0);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic expect_seq(input string tag, input int st, input int n);
    repeat (n) begin
      cyc();
      chk(tag, int'(state_out), st);
    end
  endtask

  task automatic wait_state(input int st, input int limit);
    int k = 0;
    while (int'(state_out) != st && k < limit) begin
      cyc();
      k++;
    end
    chk("wait_state", int'(state_out), st);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; ns_req = 1'b0; ew_req = 1'b0; ped_req = 1'b0;
    m_st = 0; m_t = 0; m_ped = 0; m_ew = 0;
    repeat (2) @(negedge clk);
    check_outputs();
    chk("reset_lamps", int'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}), 0);

    // Start-up through all-red, then rest on NS green.
    rst_n = 1'b1; enable = 1'b1;
    expect_seq("startup_ar", 6, 2);
    expect_seq("startup_nsg", 1, 1);
    expect_seq("rest_nsg", 1, 52);

    // Full vehicle cycle.
    ew_req = 1'b1;
    expect_seq("ns_y", 2, 1);
    ew_req = 1'b0; ns_req = 1'b1;
    expect_seq("ns_y", 2, 2);
    expect_seq("ar_ns", 3, 2);
    expect_seq("ew_g", 4, 5);
    expect_seq("ew_y", 5, 3);
    expect_seq("ar_ew", 6, 2);
    ns_req = 1'b0;
    expect_seq("ns_g_back", 1, 5);

    if (PED) begin
      ped_req = 1'b1;
      cyc();
      chk("ped_wait_set", int'(ped_wait), 1);
      ped_req = 1'b0;
      expect_seq("ped_ns_y", 2, 3);
      expect_seq("ped_ar", 3, 2);
      expect_seq("walk", 7, 1);
      chk("walk_lamp", int'(walk), 1);
      chk("walk_ped_wait", int'(ped_wait), 0);
      expect_seq("walk", 7, 3);
      expect_seq("ped_ew_g", 4, 1);

      // Press on the WALK-entry edge and during WALK are both absorbed.
      ped_req = 1'b1;
      cyc();
      ped_req = 1'b0;
      wait_state(5, 12);
      expect_seq("p4_ew_y", 5, 2);
      expect_seq("p4_ar", 6, 2);
      ped_req = 1'b1;
      expect_seq("walk_enter", 7, 1);
      chk("served", int'(ped_wait), 0);
      expect_seq("walk_ignore", 7, 1);
      ped_req = 1'b0;
      expect_seq("walk_rest", 7, 2);
      chk("walk_no_pending", int'(ped_wait), 0);
      expect_seq("after_walk", 1, 1);
      ped_req = 1'b1;
      cyc();
      chk("ped_after_walk", int'(ped_wait), 1);
      ped_req = 1'b0;
    end

    // Disable in the middle of NS yellow.
    enable = 1'b0;
    cyc();
    chk("off", int'(state_out), 0);
    enable = 1'b1;
    expect_seq("re_ar", 6, 2);
    expect_seq("re_nsg", 1, 1);
    ew_req = 1'b1;
    wait_state(2, 10);
    cyc();
    chk("ns_y_t1", int'(state_out), 2);
    enable = 1'b0; ew_req = 1'b0;
    cyc();
    chk("disable_off", int'(state_out), 0);
    chk("disable_lamps", int'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}), 0);
    enable = 1'b1;
    expect_seq("reen_ar", 6, 2);
    expect_seq("reen_nsg", 1, 1);

    // Asynchronous reset between edges while in EW green.
    ew_req = 1'b1;
    wait_state(4, 20);
    ew_req = 1'b0;
    cyc();
    #2;
    rst_n = 1'b0; enable = 1'b0;
    #1;
    chk("async_state", int'(state_out), 0);
    chk("async_lamps", int'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}), 0);
    m_st = 0; m_t = 0; m_ped = 0; m_ew = 0;
    check_outputs();
    #1;
    rst_n = 1'b1;
    expect_seq("post_reset_off", 0, 3);
    enable = 1'b1;
    expect_seq("post_reset_ar", 6, 1);

    // Randomized traffic against the model.
    repeat (3000) begin
      enable  = ($urandom_range(0, 99) != 0);
      ns_req  = ($urandom_range(0, 3) == 0);
      ew_req  = ($urandom_range(0, 3) == 0);
      ped_req = ($urandom_range(0, 15) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
